// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencing controller:
// FSM state encoding and default geometry.
package shift_seq_pkg;

    localparam int DATA_W_DEF    = 4;
    localparam int SHAMT_W_DEF   = 3;
    localparam int MAX_SHIFT_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        RESP
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Signal bundle between shift_seq_ctrl and its environment (requesters,
// result consumer and the external shift register).
interface shift_seq_ctrl_if
    import shift_seq_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) ();

    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [DATA_W-1:0]  req_data0;
    logic [DATA_W-1:0]  req_data1;
    logic [SHAMT_W-1:0] req_shamt0;
    logic [SHAMT_W-1:0] req_shamt1;
    logic               sr_load;
    logic               sr_ena;
    logic [DATA_W-1:0]  sr_data;
    logic [DATA_W-1:0]  sr_q;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [DATA_W-1:0]  rsp_data;
    logic               rsp_id;
    logic               busy;

    // Controller side.
    modport master (
        input  req_valid, req_data0, req_data1, req_shamt0, req_shamt1,
        input  sr_q, rsp_ready,
        output req_ready, sr_load, sr_ena, sr_data,
        output rsp_valid, rsp_data, rsp_id, busy
    );

    // Environment side: requesters, consumer and shift register.
    modport slave (
        output req_valid, req_data0, req_data1, req_shamt0, req_shamt1,
        output sr_q, rsp_ready,
        input  req_ready, sr_load, sr_ena, sr_data,
        input  rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: the pointer picks the winner on contention
// and moves to the other requester whenever a grant is taken.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       areset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic ptr;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= ~gnt[1];
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequences load/shift/capture jobs from two requesters onto an external
// logical-right shift register and hands the result back with a valid/ready.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int SHAMT_W   = SHAMT_W_DEF,
    parameter int MAX_SHIFT = MAX_SHIFT_DEF
) (
    input  logic               clk,
    input  logic               areset,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req_data0,
    input  logic [DATA_W-1:0]  req_data1,
    input  logic [SHAMT_W-1:0] req_shamt0,
    input  logic [SHAMT_W-1:0] req_shamt1,
    output logic               sr_load,
    output logic               sr_ena,
    output logic [DATA_W-1:0]  sr_data,
    input  logic [DATA_W-1:0]  sr_q,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_data,
    output logic               rsp_id,
    output logic               busy
);

    localparam logic [SHAMT_W-1:0] MAX_S = SHAMT_W'(MAX_SHIFT);

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         gnt;
    logic               accept;
    logic               sel;
    logic [SHAMT_W-1:0] shamt_sel;
    logic [SHAMT_W-1:0] shamt_clamped;
    logic [DATA_W-1:0]  data_q;
    logic [SHAMT_W-1:0] cnt;
    logic               id_q;

    rr_arbiter_2 u_arb (
        .clk     (clk),
        .areset  (areset),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    // Grant is only exposed in IDLE and is forced low while reset is held.
    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !areset) begin
            req_ready = gnt;
        end
    end

    always_comb begin
        accept        = |req_ready;
        sel           = req_ready[1];
        shamt_sel     = sel ? req_shamt1 : req_shamt0;
        shamt_clamped = (shamt_sel > MAX_S) ? MAX_S : shamt_sel;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            data_q   <= '0;
            id_q     <= 1'b0;
            cnt      <= '0;
            rsp_data <= '0;
            rsp_id   <= 1'b0;
        end else begin
            if (accept) begin
                data_q <= sel ? req_data1 : req_data0;
                id_q   <= sel;
                cnt    <= shamt_clamped;
            end else if (state == SHIFT) begin
                cnt <= cnt - SHAMT_W'(1);
            end
            if (state == CAPTURE) begin
                rsp_data <= sr_q;
                rsp_id   <= id_q;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sr_load   = 1'b0;
        sr_ena    = 1'b0;
        sr_data   = '0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                sr_load   = 1'b1;
                sr_data   = data_q;
                state_nxt = (cnt != '0) ? SHIFT : CAPTURE;
            end
            SHIFT: begin
                sr_ena = 1'b1;
                if (cnt <= SHAMT_W'(1)) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl driving a 4-bit logical-right shift
// register; table of single jobs plus hand-written multi-cycle sequences.
module tb_shift_seq_ctrl;
    import shift_seq_pkg::*;

    logic clk;
    logic areset;
    int   errors;
    int   checks;

    shift_seq_ctrl_if #(.DATA_W(4), .SHAMT_W(3)) bus ();

    shift_seq_ctrl #(.DATA_W(4), .SHAMT_W(3), .MAX_SHIFT(4)) dut (
        .clk        (clk),
        .areset     (areset),
        .req_valid  (bus.req_valid),
        .req_ready  (bus.req_ready),
        .req_data0  (bus.req_data0),
        .req_data1  (bus.req_data1),
        .req_shamt0 (bus.req_shamt0),
        .req_shamt1 (bus.req_shamt1),
        .sr_load    (bus.sr_load),
        .sr_ena     (bus.sr_ena),
        .sr_data    (bus.sr_data),
        .sr_q       (bus.sr_q),
        .rsp_valid  (bus.rsp_valid),
        .rsp_ready  (bus.rsp_ready),
        .rsp_data   (bus.rsp_data),
        .rsp_id     (bus.rsp_id),
        .busy       (bus.busy)
    );

    // 4-bit shift register: load has priority, shift is logical right.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            bus.sr_q <= '0;
        end else if (bus.sr_load) begin
            bus.sr_q <= bus.sr_data;
        end else if (bus.sr_ena) begin
            bus.sr_q <= bus.sr_q >> 1;
        end
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required finish before 100000");
        $fatal(1);
    end

    typedef struct {
        string      name;
        logic       rid;
        logic [3:0] data;
        logic [2:0] shamt;
        int         cnt;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        logic [1:0] oh;
        oh = v.rid ? 2'b10 : 2'b01;
        bus.req_valid = 2'b00;
        if (v.rid) begin
            bus.req_data1  = v.data;
            bus.req_shamt1 = v.shamt;
            bus.req_data0  = ~v.data;
            bus.req_shamt0 = 3'd1;
        end else begin
            bus.req_data0  = v.data;
            bus.req_shamt0 = v.shamt;
            bus.req_data1  = ~v.data;
            bus.req_shamt1 = 3'd1;
        end
        bus.req_valid = oh;
        #1;
        check({v.name, "_grant"}, 32'(bus.req_ready), 32'(oh));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        check({v.name, "_load"}, 32'({bus.sr_load, bus.sr_ena}), 32'h2);
        check({v.name, "_load_data"}, 32'(bus.sr_data), 32'(v.data));
        for (int k = 0; k < v.cnt; k++) begin
            @(negedge clk); #1;
            check({v.name, "_ena"}, 32'({bus.sr_load, bus.sr_ena, bus.busy}), 32'h3);
        end
        @(negedge clk); #1;
        check({v.name, "_capture"}, 32'({bus.sr_load, bus.sr_ena, bus.rsp_valid}), 32'h0);
        @(negedge clk); #1;
        check({v.name, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h1);
        check({v.name, "_rsp_data"}, 32'(bus.rsp_data), 32'(v.exp));
        check({v.name, "_rsp_id"}, 32'(bus.rsp_id), 32'(v.rid));
        @(negedge clk); #1;
        check({v.name, "_idle"}, 32'({bus.busy, bus.rsp_valid}), 32'h0);
    endtask

    initial begin
        logic [1:0] exp_gnt[3];
        logic       exp_id[3];
        logic [3:0] exp_dat[3];
        int n;

        errors = 0;
        checks = 0;
        tbl[0] = '{"r0_b1011_s2", 1'b0, 4'b1011, 3'd2, 2, 4'b0010};
        tbl[1] = '{"r1_b1111_s0", 1'b1, 4'b1111, 3'd0, 0, 4'b1111};
        tbl[2] = '{"r0_b1111_s7", 1'b0, 4'b1111, 3'd7, 4, 4'b0000};
        tbl[3] = '{"r1_b1000_s4", 1'b1, 4'b1000, 3'd4, 4, 4'b0000};
        tbl[4] = '{"r0_b1111_s5", 1'b0, 4'b1111, 3'd5, 4, 4'b0000};
        tbl[5] = '{"r1_b1010_s3", 1'b1, 4'b1010, 3'd3, 3, 4'b0001};
        tbl[6] = '{"r0_b0110_s1", 1'b0, 4'b0110, 3'd1, 1, 4'b0011};
        exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
        exp_id[0]  = 1'b0;  exp_id[1]  = 1'b1;  exp_id[2]  = 1'b0;
        exp_dat[0] = 4'b0010; exp_dat[1] = 4'b1010; exp_dat[2] = 4'b0010;

        // Reset with both requesters pending: every output must stay low.
        areset         = 1'b1;
        bus.rsp_ready  = 1'b1;
        bus.req_valid  = 2'b11;
        bus.req_data0  = 4'b0101;
        bus.req_shamt0 = 3'd1;
        bus.req_data1  = 4'b1010;
        bus.req_shamt1 = 3'd0;
        @(negedge clk); #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_sr", 32'({bus.sr_load, bus.sr_ena, bus.sr_data}), 32'h0);
        check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_data, bus.rsp_id}), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        areset = 1'b0;
        #1;

        // Round-robin with both requesters valid from the first edge.
        for (int j = 0; j < 3; j++) begin
            n = 0;
            while (bus.req_ready == 2'b00 && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check("rr_grant", 32'(bus.req_ready), 32'(exp_gnt[j]));
            n = 0;
            @(negedge clk); #1;
            while (!bus.rsp_valid && n < 20) begin
                @(negedge clk); #1; n++;
            end
            check("rr_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("rr_rsp_id", 32'(bus.rsp_id), 32'(exp_id[j]));
            check("rr_rsp_data", 32'(bus.rsp_data), 32'(exp_dat[j]));
            if (j == 2) bus.req_valid = 2'b00;
            @(negedge clk); #1;
        end

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i]);
        end

        // Consumer stall: result held, nothing granted, IDLE after handshake.
        bus.rsp_ready  = 1'b0;
        bus.req_data0  = 4'b1100;
        bus.req_shamt0 = 3'd1;
        bus.req_valid  = 2'b01;
        #1;
        check("stall_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        for (int k = 0; k < 10; k++) begin
            check("stall_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("stall_rsp_data", 32'(bus.rsp_data), 32'h6);
            check("stall_rsp_id", 32'(bus.rsp_id), 32'h0);
            check("stall_req_ready", 32'(bus.req_ready), 32'h0);
            @(negedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b00;
        #1;
        check("stall_release_valid", 32'(bus.rsp_valid), 32'h1);
        @(negedge clk); #1;
        check("stall_idle", 32'({bus.busy, bus.rsp_valid}), 32'h0);
        @(negedge clk); #1;
        check("dropped_req_no_effect", 32'(bus.busy), 32'h0);

        // Reset in the middle of SHIFT; pointer must come back to requester 0.
        bus.req_data0  = 4'b1111;
        bus.req_shamt0 = 3'd4;
        bus.req_valid  = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        check("midrst_shifting", 32'(bus.sr_ena), 32'h1);
        #2;
        areset        = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_data0 = 4'b0011;
        bus.req_shamt0 = 3'd0;
        #1;
        check("midrst_sr_ena", 32'(bus.sr_ena), 32'h0);
        check("midrst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'h0);
        check("midrst_req_ready", 32'(bus.req_ready), 32'h0);
        @(negedge clk);
        @(negedge clk);
        areset = 1'b0;
        #1;
        check("postrst_grant", 32'(bus.req_ready), 32'h1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        check("postrst_load", 32'({bus.sr_load, bus.sr_data}), 32'h13);
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk); #1; n++;
        end
        check("postrst_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("postrst_rsp", 32'({bus.rsp_id, bus.rsp_data}), 32'h03);
        @(negedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 4, width of the shift-register word.
- SHAMT_W, 3, width of the shift-count fields.
- MAX_SHIFT, 4, largest shift count honoured.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning (clock and reset first):
- clk  in  1  single clock; all state updates on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester job request; bit i belongs to requester i.
- req_ready  out  2  per-requester accept; a job transfers when req_valid[i] and req_ready[i] are both high.
- req_data0 / req_data1  in  DATA_W  word to load for requester 0 / 1.
- req_shamt0 / req_shamt1  in  SHAMT_W  number of shift (ena) cycles for requester 0 / 1.
- sr_load  out  1  load strobe to the shift register.
- sr_ena  out  1  shift-enable strobe to the shift register.
- sr_data  out  DATA_W  parallel load word to the shift register.
- sr_q  in  DATA_W  shift-register output (registered; load has priority over ena; shift is logical right).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  DATA_W  shifted result.
- rsp_id  out  1  requester that owns the result.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 The FSM SHALL have the states IDLE, LOAD, SHIFT, CAPTURE and RESP.
REQ-004 In IDLE, req_ready SHALL be a one-hot grant to a valid requester, driven combinationally. req_ready SHALL be 0 in all other states.
REQ-005 Arbitration SHALL be round-robin. When both requesters are valid, the requester selected by the pointer wins. On each accepted job the pointer moves to the other requester.
REQ-006 On acceptance the block SHALL latch data, id and the shift count min(shamt, MAX_SHIFT), then go to LOAD.
REQ-007 LOAD SHALL last exactly one cycle with sr_load=1 and sr_data equal to the latched data. The next state is SHIFT if the count is non-zero, otherwise CAPTURE.
REQ-008 SHIFT SHALL hold sr_ena=1 for exactly count consecutive cycles, then go to CAPTURE.
REQ-009 CAPTURE SHALL last one cycle and register sr_q into rsp_data.
REQ-010 RESP SHALL hold rsp_valid=1 with rsp_data and rsp_id stable until rsp_ready=1. It then returns to IDLE on the next cycle.
REQ-011 sr_load and sr_ena SHALL never be high together. sr_data SHALL be 0 outside LOAD.
REQ-012 Latency SHALL be as follows, for acceptance in cycle T:
- sr_load in cycle T+1.
- sr_ena in cycles T+2 .. T+1+count.
- rsp_valid first high in cycle T+3+count.
REQ-013 If rsp_ready is low, RESP SHALL stall indefinitely and no new job SHALL be accepted.
REQ-014 A shamt greater than MAX_SHIFT SHALL clamp to MAX_SHIFT, which yields a result of 0.
REQ-015 A request whose req_valid is dropped before it is granted SHALL have no effect.

Reset
REQ-016 While areset is high, and immediately on its assertion, the block SHALL return to IDLE, including mid-job.
REQ-017 During reset all outputs SHALL be 0: req_ready, sr_load, sr_ena, sr_data, rsp_valid, rsp_data, rsp_id and busy.
REQ-018 During reset the round-robin pointer SHALL be set to requester 0 and the shift counter to 0.
REQ-019 The first rising edge after areset deasserts SHALL be able to accept a job.

Structure
REQ-020 A shared package shift_seq_pkg SHALL hold the FSM state enum and the DATA_W, SHAMT_W and MAX_SHIFT defaults.
REQ-021 Round-robin grant logic SHALL be a single sub-module, rr_arbiter_2, with inputs req[1:0], advance, clk and areset, and output gnt[1:0].

Verification
REQ-022 The bench SHALL connect the team's 4-bit shift register to the sr_* ports and cover:
- Requester 0 sends data 4'b1011, shamt 2, with rsp_ready=1 → sr_load at T+1, sr_ena at T+2..T+3, rsp_data 4'b0010 and rsp_id 0 at T+5.
- Both requesters valid for three jobs after reset → grants in the order 0, 1, 0; each rsp_id matches its grant.
- shamt 0 with data 4'b1111 → no sr_ena pulse; rsp_data 4'b1111 at T+3.
- shamt 7 with data 4'b1111 → exactly 4 ena pulses; rsp_data 4'b0000.
- rsp_ready held low for 10 cycles with data 4'b1100, shamt 1 → rsp_valid and rsp_data 4'b0110 stable throughout, req_ready stays 0, IDLE follows the handshake.
- areset pulsed during SHIFT → sr_ena, rsp_valid and busy go to 0 at once; the next request is granted to requester 0.
